// File: rtl/imem_port_arbiter_if.sv
// Instruction-memory port bundle: fetch requester, loader/debug requester and the
// single-ported memory, seen from the arbiter (master) and from its environment (slave).
interface imem_port_arbiter_if #(
  parameter int DBITS        = 32,
  parameter int IMEMADDRBITS = 16,
  parameter int IMEMWORDBITS = 2
);
  logic                                 fe_req;
  logic [DBITS-1:0]                     fe_addr;
  logic                                 fe_gnt;
  logic                                 fe_stall;
  logic                                 fe_rvalid;
  logic [DBITS-1:0]                     fe_rdata;

  logic                                 ld_req;
  logic                                 ld_we;
  logic                                 ld_lock;
  logic [DBITS-1:0]                     ld_addr;
  logic [DBITS-1:0]                     ld_wdata;
  logic                                 ld_gnt;
  logic                                 ld_rvalid;
  logic [DBITS-1:0]                     ld_rdata;

  logic                                 mem_en;
  logic                                 mem_we;
  logic [IMEMADDRBITS-IMEMWORDBITS-1:0] mem_addr;
  logic [DBITS-1:0]                     mem_wdata;
  logic [DBITS-1:0]                     mem_rdata;

  modport master (
    input  fe_req, fe_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    output fe_gnt, fe_stall, fe_rvalid, fe_rdata, ld_gnt, ld_rvalid, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output fe_req, fe_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    input  fe_gnt, fe_stall, fe_rvalid, fe_rdata, ld_gnt, ld_rvalid, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Fetch-priority arbiter for the instruction-memory port with a loader starvation
// guard, exclusive loader lock mode and 1-cycle read response routing.
module imem_port_arbiter #(
  parameter int DBITS        = 32,
  parameter int IMEMADDRBITS = 16,
  parameter int IMEMWORDBITS = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  imem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {FETCH, LOCKED, DRAIN} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       fe_gnt, ld_gnt, ld_force;
  logic       fe_tag, ld_tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = '0;
    case (state)
      FETCH: begin
        if (bus.ld_lock) state_nxt = LOCKED;
        if (bus.ld_req && !ld_gnt)
          starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
      end
      LOCKED:  if (!bus.ld_lock) state_nxt = DRAIN;
      default: state_nxt = FETCH;
    endcase
  end

  // Grants are forced low while reset is held so the memory sees no access.
  always_comb begin
    fe_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    ld_force = bus.ld_req && (starve_cnt == STARVE_MAX);
    if (reset) begin
      case (state)
        FETCH: begin
          if (ld_force)        ld_gnt = 1'b1;
          else if (bus.fe_req) fe_gnt = 1'b1;
          else if (bus.ld_req) ld_gnt = 1'b1;
        end
        LOCKED:  ld_gnt = bus.ld_req;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fe_tag <= 1'b0;
      ld_tag <= 1'b0;
    end else begin
      fe_tag <= fe_gnt;
      ld_tag <= ld_gnt && !bus.ld_we;
    end
  end

  assign bus.fe_gnt    = fe_gnt;
  assign bus.ld_gnt    = ld_gnt;
  assign bus.fe_stall  = bus.fe_req && !fe_gnt;

  assign bus.mem_en    = fe_gnt | ld_gnt;
  assign bus.mem_we    = ld_gnt & bus.ld_we;
  assign bus.mem_addr  = ld_gnt ? bus.ld_addr[IMEMADDRBITS-1:IMEMWORDBITS] :
                         fe_gnt ? bus.fe_addr[IMEMADDRBITS-1:IMEMWORDBITS] : '0;
  assign bus.mem_wdata = (fe_gnt | ld_gnt) ? bus.ld_wdata : '0;

  assign bus.fe_rvalid = fe_tag;
  assign bus.ld_rvalid = ld_tag;
  assign bus.fe_rdata  = bus.mem_rdata;
  assign bus.ld_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: synchronous memory stand-in, a rule-level
// reference model checked every cycle, and literal checks on the planned scenarios.
module tb_imem_port_arbiter;
  localparam int DBITS  = 32;
  localparam int ABITS  = 16;
  localparam int WBITS  = 2;
  localparam int LIMIT  = 8;
  localparam int NWORDS = 1 << (ABITS - WBITS);

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  imem_port_arbiter_if #(.DBITS(DBITS), .IMEMADDRBITS(ABITS), .IMEMWORDBITS(WBITS)) bus ();

  imem_port_arbiter #(
    .DBITS(DBITS), .IMEMADDRBITS(ABITS), .IMEMWORDBITS(WBITS), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] init_word(int w);
    return 32'h5A00_0000 + 32'(w) * 32'h0000_0101;
  endfunction

  logic [31:0] mem    [0:NWORDS-1];
  logic [31:0] shadow [0:NWORDS-1];

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = fetch-priority, 1 = loader owns port, 2 = bubble.
  int          mode = 0;
  int          denied = 0;
  bit          pv_fe = 0, pv_ld = 0;
  logic [31:0] pv_data = '0;

  always @(negedge clk) begin
    bit          e_fe, e_ld;
    logic [31:0] a;
    int          word;
    if (!reset) begin
      mode = 0; denied = 0; pv_fe = 0; pv_ld = 0;
      chk("rst_fe_gnt", 32'(bus.fe_gnt), 0);
      chk("rst_ld_gnt", 32'(bus.ld_gnt), 0);
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_fe_rvalid", 32'(bus.fe_rvalid), 0);
      chk("rst_ld_rvalid", 32'(bus.ld_rvalid), 0);
    end else begin
      e_fe = 0; e_ld = 0;
      if (mode == 0) begin
        if (bus.ld_req && denied >= LIMIT) e_ld = 1;
        else if (bus.fe_req)               e_fe = 1;
        else if (bus.ld_req)               e_ld = 1;
      end else if (mode == 1) begin
        e_ld = bus.ld_req;
      end
      a    = e_ld ? bus.ld_addr : bus.fe_addr;
      word = int'((a % 32'h1_0000) / 4);
      chk("fe_gnt", 32'(bus.fe_gnt), 32'(e_fe));
      chk("ld_gnt", 32'(bus.ld_gnt), 32'(e_ld));
      chk("fe_stall", 32'(bus.fe_stall), 32'(bus.fe_req && !e_fe));
      chk("mem_en", 32'(bus.mem_en), 32'(e_fe || e_ld));
      chk("mem_we", 32'(bus.mem_we), 32'(e_ld && bus.ld_we));
      chk("mem_addr", 32'(bus.mem_addr), (e_fe || e_ld) ? 32'(word) : 0);
      chk("mem_wdata", bus.mem_wdata, (e_fe || e_ld) ? bus.ld_wdata : 0);
      chk("fe_rvalid", 32'(bus.fe_rvalid), 32'(pv_fe));
      chk("ld_rvalid", 32'(bus.ld_rvalid), 32'(pv_ld));
      if (pv_fe || pv_ld) begin
        chk("fe_rdata", bus.fe_rdata, pv_data);
        chk("ld_rdata", bus.ld_rdata, pv_data);
      end
      pv_fe = e_fe;
      pv_ld = e_ld && !bus.ld_we;
      if (e_ld && bus.ld_we)  shadow[word] = bus.ld_wdata;
      else if (e_fe || e_ld)  pv_data = shadow[word];
      if (mode == 0 && bus.ld_req && !e_ld) denied++;
      else                                  denied = 0;
      case (mode)
        0:       if (bus.ld_lock) mode = 1;
        1:       if (!bus.ld_lock) mode = 2;
        default: mode = 0;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fe_req = 0; bus.fe_addr = '0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_lock = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    repeat (3) tick;
    reset = 1'b1;

    // sequential fetch at PC 0, 4, 8
    for (int i = 0; i < 4; i++) begin
      tick;
      bus.fe_req  = (i < 3);
      bus.fe_addr = 32'(4 * i);
      @(negedge clk);
      if (i < 3) begin
        chk("seq_fe_gnt", 32'(bus.fe_gnt), 1);
        chk("seq_mem_addr", 32'(bus.mem_addr), 32'(i));
      end
      if (i > 0) begin
        chk("seq_fe_rvalid", 32'(bus.fe_rvalid), 1);
        chk("seq_fe_rdata", bus.fe_rdata, (i == 1) ? 32'h5A00_0000 :
                                          (i == 2) ? 32'h5A00_0101 : 32'h5A00_0202);
      end
    end

    // starvation guard: loader forced in on the 9th contended cycle, twice
    tick;
    bus.fe_req = 1; bus.fe_addr = 32'h40;
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 32'h100;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick;
      @(negedge clk);
      if (c < 9) chk("starve_fe_wins", 32'({bus.fe_gnt, bus.ld_gnt}), 32'b10);
      else begin
        chk("starve_ld_gnt", 32'(bus.ld_gnt), 1);
        chk("starve_fe_stall", 32'(bus.fe_stall), 1);
        chk("starve_mem_addr", 32'(bus.mem_addr), 32'h40);
      end
    end
    for (int c = 1; c <= 9; c++) begin
      tick;
      @(negedge clk);
      if (c == 1) begin
        chk("starve_ld_rvalid", 32'(bus.ld_rvalid), 1);
        chk("starve_ld_rdata", bus.ld_rdata, 32'h5A00_4040);
        chk("starve_cnt_cleared", 32'(bus.ld_gnt), 0);
      end
      if (c == 9) chk("starve_again_ld_gnt", 32'(bus.ld_gnt), 1);
    end
    tick;
    bus.fe_req = 0; bus.ld_req = 0;

    // exclusive lock with four writes while fetch waits
    tick;
    bus.fe_req = 1; bus.fe_addr = 32'h0;
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_lock = 1; bus.ld_addr = 32'h0; bus.ld_wdata = 32'hCAFE_0000;
    @(negedge clk);
    chk("lock_first_fe_gnt", 32'({bus.fe_gnt, bus.ld_gnt}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      tick;
      bus.ld_addr  = 32'(4 * i);
      bus.ld_wdata = 32'hCAFE_0000 + 32'(i);
      @(negedge clk);
      chk("lock_ld_gnt", 32'(bus.ld_gnt), 1);
      chk("lock_mem_we", 32'(bus.mem_we), 1);
      chk("lock_fe_stall", 32'(bus.fe_stall), 1);
      chk("lock_mem_addr", 32'(bus.mem_addr), 32'(i));
    end
    tick;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_lock = 0;
    @(negedge clk);
    chk("unlock_no_gnt", 32'(bus.mem_en), 0);
    tick;
    @(negedge clk);
    chk("drain_no_gnt", 32'(bus.mem_en), 0);
    chk("drain_fe_stall", 32'(bus.fe_stall), 1);
    tick;
    @(negedge clk);
    chk("post_drain_fe_gnt", 32'(bus.fe_gnt), 1);
    tick;
    bus.fe_req = 0;
    @(negedge clk);
    chk("post_drain_rdata", bus.fe_rdata, 32'hCAFE_0000);

    // write then read-after-write of the same word
    tick;
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("raw_write_addr", 32'(bus.mem_addr), 32'h8);
    tick;
    bus.ld_req = 0; bus.ld_we = 0; bus.fe_req = 1; bus.fe_addr = 32'h20;
    tick;
    bus.fe_req = 0;
    @(negedge clk);
    chk("raw_fe_rdata", bus.fe_rdata, 32'h1234_5678);

    // upper address bits ignored
    tick;
    bus.ld_req = 1; bus.ld_addr = 32'h0001_0004;
    @(negedge clk);
    chk("wrap_mem_addr", 32'(bus.mem_addr), 32'h1);
    tick;
    bus.ld_req = 0;
    @(negedge clk);
    chk("wrap_ld_rdata", bus.ld_rdata, 32'hCAFE_0001);

    // reset with a fetch read in flight
    tick;
    bus.fe_req = 1; bus.fe_addr = 32'h8;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("inflight_rvalid_dropped", 32'(bus.fe_rvalid), 0);
    chk("inreset_fe_gnt", 32'(bus.fe_gnt), 0);
    tick;
    reset = 1'b1;
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 32'h100;
    @(negedge clk);
    chk("post_rst_fe_rvalid", 32'(bus.fe_rvalid), 0);
    chk("post_rst_fetch", 32'({bus.fe_gnt, bus.ld_gnt}), 32'b10);
    for (int c = 2; c <= 9; c++) begin
      tick;
      @(negedge clk);
      if (c == 9) chk("post_rst_starve_ld_gnt", 32'(bus.ld_gnt), 1);
    end
    tick;
    bus.fe_req = 0; bus.ld_req = 0;
    repeat (2) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates the single instruction-memory port between the fetch stage and the program loader/debug requester. Fetch has priority, with a starvation guard that guarantees loader progress, and an exclusive lock mode for bulk program loading. The block drives the memory port, routes 1-cycle-latency read data back to the requester that issued the read, and raises a fetch stall that the FE stage ORs into its stall term.

## Interface
Parameters:
- DBITS, 32, data/address width of both requesters
- IMEMADDRBITS, 16, byte-address bits that index the memory
- IMEMWORDBITS, 2, byte-offset bits dropped to form the word address
- STARVE_LIMIT, 8, consecutive denied loader cycles before a forced loader grant (range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- fe_req  in  1  fetch read request
- fe_addr  in  DBITS  fetch byte address (PC)
- fe_gnt  out  1  fetch granted this cycle
- fe_stall  out  1  fe_req && !fe_gnt
- fe_rvalid  out  1  fe_rdata valid (read granted previous cycle)
- fe_rdata  out  DBITS  instruction word
- ld_req  in  1  loader request
- ld_we  in  1  loader write (1) / read (0)
- ld_lock  in  1  loader requests exclusive ownership
- ld_addr  in  DBITS  loader byte address
- ld_wdata  in  DBITS  loader write data
- ld_gnt  out  1  loader granted this cycle
- ld_rvalid  out  1  ld_rdata valid
- ld_rdata  out  DBITS  loader read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  IMEMADDRBITS-IMEMWORDBITS  word address
- mem_wdata  out  DBITS  write data
- mem_rdata  in  DBITS  synchronous read data, valid the cycle after mem_en && !mem_we

## Operation
- States: FETCH, LOCKED, DRAIN. Reset state FETCH.
- FETCH grant rule (combinational): if ld_req && starve_cnt == STARVE_LIMIT then loader; else if fe_req then fetch; else if ld_req then loader; else none.
- LOCKED: only the loader is granted; fe_gnt = 0 and fe_stall = fe_req.
- DRAIN: no grants (one bubble cycle); the last loader read response is delivered.
- Transitions: FETCH -> LOCKED when ld_lock = 1 (arbitration in that same cycle follows the FETCH rule); LOCKED -> DRAIN when ld_lock = 0; DRAIN -> FETCH unconditionally.
- starve_cnt (4-bit): in FETCH, increments (saturating at STARVE_LIMIT) when ld_req && !ld_gnt; clears on ld_gnt, when ld_req = 0, and in LOCKED/DRAIN.
- Memory drive: mem_en = fe_gnt | ld_gnt; mem_we = ld_gnt & ld_we; mem_addr = granted address[IMEMADDRBITS-1:IMEMWORDBITS]; upper address bits are ignored, so addresses wrap modulo 2^IMEMADDRBITS. mem_wdata = ld_wdata. Outputs are 0 when no grant.
- Response routing: a registered tag records the owner of a granted read. The next cycle, fe_rvalid or ld_rvalid = 1 for that owner, and both fe_rdata and ld_rdata = mem_rdata. Loader writes produce no rvalid.

## Timing
- Grants and mem_* are combinational from state, starve_cnt and requests. There is no request-to-grant latency.
- Read latency: grant in cycle N -> rvalid and data in cycle N+1. Back-to-back reads sustain one response per cycle.
- A write in cycle N followed by a read of the same word in N+1 returns the new data.
- Reset assertion (async): state = FETCH, starve_cnt = 0, read tag cleared, fe_rvalid = ld_rvalid = 0, and all grants and mem_* are 0 while reset is held. An in-flight read response is discarded.
- Requesters hold their request and address until granted. Dropping a request before grant is legal and causes no access.

## Test plan
- Reset then fe_req = 1 every cycle at PC 0x0, 0x4, 0x8: fe_gnt = 1 each cycle, mem_addr = 0, 1, 2, and fe_rvalid = 1 in the following cycles with matching data.
- fe_req and ld_req held high (read at 0x100), STARVE_LIMIT = 8: fetch is granted for 8 cycles, ld_gnt = 1 on the 9th cycle with fe_stall = 1 that cycle, ld_rvalid = 1 the next cycle, and starve_cnt returns to 0.
- ld_lock = 1 with writes to 0x0..0xC while fe_req = 1: FETCH for one cycle, then LOCKED with fe_stall = 1 throughout and mem_we = 1 for 4 cycles. ld_lock = 0 gives one DRAIN cycle with no grant, then fetch of 0x0 returns the newly written word.
- Loader write to 0x20 in cycle N, fetch read 0x20 in N+1: fe_rdata equals the written value.
- Address wrap: ld_addr = 0x0001_0004 with IMEMADDRBITS = 16 gives mem_addr = 1.
- Reset asserted while a read is in flight: no rvalid appears after reset release, state is FETCH, and starve_cnt = 0.
